// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake of the load/store unit.
// The master modport is the execute stage; the slave modport is the LSU.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32 load/store controller in front of a word-wide DataMem.
// Sub-word stores are done as read-modify-write; all outputs are registered.
module load_store_unit #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic [31:0]        mem_addr,
  output logic [31:0]        mem_write_value,
  output logic               mem_write_enable,
  output logic               mem_read_enable,
  input  logic [31:0]        mem_read_value
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  state_t              state;
  logic                write_q;
  logic [2:0]          funct3_q;
  logic [1:0]          addr_lo_q;
  logic [HALF_W-1:0]   wdata_q;

  logic                f3_ok;
  logic                misaligned;
  logic                out_of_range;
  logic                legal;
  logic [BYTE_W-1:0]   lane_byte;
  logic [HALF_W-1:0]   lane_half;
  logic [WORD_W-1:0]   load_data;
  logic [WORD_W-1:0]   merge_word;

  // Legality of the request presented on the bus
  always_comb begin
    f3_ok = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !bus.req_write;
      default:                f3_ok = 1'b0;
    endcase
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = bus.req_addr >= 32'(DEPTH);
    legal        = f3_ok && !misaligned && !out_of_range;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_byte  = mem_read_value[{addr_lo_q, 3'b000} +: BYTE_W];
    lane_half  = mem_read_value[{addr_lo_q[1], 4'b0000} +: HALF_W];
    load_data  = '0;
    case (funct3_q)
      3'b000:  load_data = {{(WORD_W-BYTE_W){lane_byte[BYTE_W-1]}}, lane_byte};
      3'b001:  load_data = {{(WORD_W-HALF_W){lane_half[HALF_W-1]}}, lane_half};
      3'b010:  load_data = mem_read_value;
      3'b100:  load_data = {{(WORD_W-BYTE_W){1'b0}}, lane_byte};
      3'b101:  load_data = {{(WORD_W-HALF_W){1'b0}}, lane_half};
      default: load_data = '0;
    endcase
    merge_word = mem_read_value;
    if (funct3_q[1:0] == 2'b00)
      merge_word[{addr_lo_q, 3'b000} +: BYTE_W] = wdata_q[BYTE_W-1:0];
    else
      merge_word[{addr_lo_q[1], 4'b0000} +: HALF_W] = wdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      write_q          <= 1'b0;
      funct3_q         <= '0;
      addr_lo_q        <= '0;
      wdata_q          <= '0;
      bus.req_ready    <= 1'b1;
      bus.resp_valid   <= 1'b0;
      bus.resp_rdata   <= '0;
      bus.resp_err     <= 1'b0;
      mem_addr         <= '0;
      mem_write_value  <= '0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
    end else begin
      bus.resp_valid   <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q       <= bus.req_write;
            funct3_q      <= bus.req_funct3;
            addr_lo_q     <= bus.req_addr[1:0];
            wdata_q       <= bus.req_wdata[HALF_W-1:0];
            bus.req_ready <= 1'b0;
            if (!legal) begin
              state          <= RESP;
              bus.resp_valid <= 1'b1;
              bus.resp_err   <= 1'b1;
              bus.resp_rdata <= '0;
            end else begin
              mem_addr <= {bus.req_addr[31:2], 2'b00};
              // Full-word stores skip the read phase
              if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
                state            <= WRITE;
                mem_write_enable <= 1'b1;
                mem_write_value  <= bus.req_wdata;
              end else begin
                state           <= READ;
                mem_read_enable <= 1'b1;
              end
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          if (write_q) begin
            state            <= WRITE;
            mem_write_enable <= 1'b1;
            mem_write_value  <= merge_word;
          end else begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= load_data;
          end
        end
        WRITE: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        RESP: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_err   <= 1'b0;
          bus.resp_rdata <= '0;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word-wide DataMem.
module tb_load_store_unit;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] mem_addr, mem_write_value, mem_read_value;
  logic        mem_write_enable, mem_read_enable;

  load_store_unit_if bus ();

  load_store_unit #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .mem_addr         (mem_addr),
    .mem_write_value  (mem_write_value),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_value   (mem_read_value)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] mem_rd = '0;
  assign mem_read_value = mem_rd;
  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_addr[9:2]] <= mem_write_value;
    if (mem_read_enable)  mem_rd <= mem[mem_addr[9:2]];
  end

  int errors = 0, checks = 0;
  int acc_cnt = 0, resp_cnt = 0, overlap = 0, bad_ready = 0, bad_addr = 0;
  int exp_acc = 0, exp_resp = 0;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.req_valid && bus.req_ready) acc_cnt++;
      if (bus.resp_valid) resp_cnt++;
      if (mem_read_enable && mem_write_enable) overlap++;
      if (bus.req_ready && (mem_read_enable || mem_write_enable || bus.resp_valid)) bad_ready++;
      if ((mem_read_enable || mem_write_enable) &&
          ((mem_addr[31:10] != '0) || (mem_addr[1:0] != 2'b00))) bad_addr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to its response, counting memory enables
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int nre, output int nwe, output int we_at);
    int guard = 0;
    while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_acc++;
    lat = 1; nre = 0; nwe = 0; we_at = 0;
    while (1) begin
      nre += int'(mem_read_enable);
      nwe += int'(mem_write_enable);
      if (mem_write_enable) we_at = lat;
      if (bus.resp_valid || lat >= 20) break;
      @(posedge clk); #1; lat++;
    end
    if (bus.resp_valid) exp_resp++;
    rd = bus.resp_rdata; er = bus.resp_err;
    @(posedge clk); #1;
  endtask

  task automatic st(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] rd; logic er; int lat, nre, nwe, we_at;
    do_req(1'b1, f3, a, wd, rd, er, lat, nre, nwe, we_at);
    check({tag, ".err"}, 32'(er), 32'd0);
    check({tag, ".lat"}, 32'(lat), (f3 == 3'b010) ? 32'd2 : 32'd4);
    check({tag, ".nwe"}, 32'(nwe), 32'd1);
    check({tag, ".we_at"}, 32'(we_at), (f3 == 3'b010) ? 32'd1 : 32'd3);
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er; int lat, nre, nwe, we_at;
    do_req(1'b0, f3, a, 32'h0, rd, er, lat, nre, nwe, we_at);
    check({tag, ".err"}, 32'(er), 32'd0);
    check({tag, ".lat"}, 32'(lat), 32'd3);
    check({tag, ".data"}, rd, exp);
    check({tag, ".en"}, 32'(nre * 16 + nwe), 32'h10);
  endtask

  task automatic bad(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] rd; logic er; int lat, nre, nwe, we_at;
    do_req(w, f3, a, 32'hDEAD_BEEF, rd, er, lat, nre, nwe, we_at);
    check({tag, ".err"}, 32'(er), 32'd1);
    check({tag, ".lat"}, 32'(lat), 32'd1);
    check({tag, ".en"}, 32'(nre + nwe), 32'd0);
    check({tag, ".data"}, rd, 32'h0);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0;
    #12;
    check("rst.ready", 32'(bus.req_ready), 32'd1);
    check("rst.resp", {29'd0, bus.resp_valid, bus.resp_err, mem_read_enable}, 32'd0);
    check("rst.we", 32'(mem_write_enable), 32'd0);
    check("rst.rdata", bus.resp_rdata, 32'h0);
    check("rst.maddr", mem_addr, 32'h0);
    check("rst.mwv", mem_write_value, 32'h0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    st("sw0", 3'b010, 32'h0, 32'hAABBCCDD);
    ld("lw0", 3'b010, 32'h0, 32'hAABBCCDD);

    st("sw4", 3'b010, 32'h4, 32'h11223344);
    ld("lb7", 3'b000, 32'h7, 32'h00000011);
    ld("lbu6", 3'b100, 32'h6, 32'h00000022);
    ld("lh4", 3'b001, 32'h4, 32'h00003344);
    st("sw4b", 3'b010, 32'h4, 32'hFFFF8080);
    ld("lh4b", 3'b001, 32'h4, 32'hFFFF8080);
    ld("lhu4", 3'b101, 32'h4, 32'h00008080);
    ld("lb4", 3'b000, 32'h4, 32'hFFFFFF80);
    ld("lh6", 3'b001, 32'h6, 32'hFFFFFFFF);

    st("sw8", 3'b010, 32'h8, 32'hAABBCCDD);
    st("sb9", 3'b000, 32'h9, 32'hFFFFFF55);
    st("sha", 3'b001, 32'hA, 32'hFFFF1234);
    ld("lw8", 3'b010, 32'h8, 32'h123455DD);

    bad("lh1", 1'b0, 3'b001, 32'h1);
    bad("sw2", 1'b1, 3'b010, 32'h2);
    bad("lwdepth", 1'b0, 3'b010, 32'(DEPTH));
    bad("f3_011", 1'b0, 3'b011, 32'h0);
    bad("st_f3_100", 1'b1, 3'b100, 32'h0);
    ld("lwlast", 3'b010, 32'(DEPTH - 4), 32'h0);

    // Reset while an SB read-modify-write sits in WAIT
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h77;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    exp_acc++;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid.ready", 32'(bus.req_ready), 32'd1);
    check("mid.en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check("mid.resp", {30'd0, bus.resp_valid, bus.resp_err}, 32'd0);
    check("mid.maddr", mem_addr, 32'h0);
    check("mid.mwv", mem_write_value, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ld("lw0_after_rst", 3'b010, 32'h0, 32'hAABBCCDD);

    // req_valid held high across alternating SW/LW
    bus.req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      automatic logic [31:0] a = 32'h20 + 32'(4 * (k / 2));
      automatic logic [31:0] v = 32'hC0DE0000 + 32'(k / 2);
      automatic int guard = 0;
      automatic int lat = 1;
      bus.req_write = ((k % 2) == 0); bus.req_funct3 = 3'b010;
      bus.req_addr = a; bus.req_wdata = v;
      while (!bus.req_ready && guard < 20) begin @(posedge clk); #1; guard++; end
      @(posedge clk); #1;
      exp_acc++;
      while (!bus.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      if (bus.resp_valid) exp_resp++;
      check("hold.lat", 32'(lat), ((k % 2) == 0) ? 32'd2 : 32'd3);
      if ((k % 2) == 1) check("hold.data", bus.resp_rdata, v);
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    check("acc_cnt", 32'(acc_cnt), 32'(exp_acc));
    check("resp_cnt", 32'(resp_cnt), 32'(exp_resp));
    check("overlap", 32'(overlap), 32'd0);
    check("ready_busy", 32'(bad_ready), 32'd0);
    check("mem_addr_fmt", 32'(bad_addr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequential load/store controller between the core's execute stage and the word-wide `DataMem`. Accepts one RV32 load/store request at a time (LB/LH/LW/LBU/LHU/SB/SH/SW) and performs alignment checks and byte-lane selection. Loads are sign- or zero-extended. Sub-word stores become a read-modify-write, because `DataMem` only writes whole words. Returns a one-cycle response pulse carrying load data or an error flag.

## Interface
- `DEPTH`, 1024: `DataMem` size in bytes; must be a power of two and at least 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  high only in IDLE; a request is accepted on a rising edge where `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 width/sign code.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; the low byte/half is used for SB/SH.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data, valid with `resp_valid`; 0 for stores and errors.
- `resp_err`  out  1  valid with `resp_valid`; request was misaligned, out of range or had an illegal funct3.
- `mem_addr`  out  32  word-aligned address to `DataMem` (`{addr[31:2],2'b00}`).
- `mem_write_value`  out  32  word to write.
- `mem_write_enable`  out  1  `DataMem` writes `mem_write_value` at the rising edge where this is high.
- `mem_read_enable`  out  1  read request; `mem_read_value` is valid in the following cycle.
- `mem_read_value`  in  32  word read from `DataMem`.

## Operation
- FSM states:
  - IDLE: `req_ready`=1.
  - READ: `mem_read_enable`=1.
  - WAIT: capture `mem_read_value`.
  - WRITE: `mem_write_enable`=1.
  - RESP: `resp_valid`=1.
- All outputs are registered or decoded from state and latched request registers. No combinational path runs from `req_*` to `mem_*`.
- On accept, latch `write`, `funct3`, `addr` and `wdata`, then check legality:
  - Legal load funct3: 000, 001, 010, 100, 101. Legal store funct3: 000, 001, 010.
  - Misaligned: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Out of range: `addr` ≥ `DEPTH`. Words at `DEPTH-4` and above, up to `DEPTH-1`, are legal.
  - Any failure: next state RESP with `resp_err`=1. Memory is untouched.
- Next state after a legal accept:
  - Load → READ → WAIT → RESP.
  - SW → WRITE (`mem_write_value`=`wdata`) → RESP.
  - SB/SH → READ → WAIT → WRITE → RESP.
- Byte lanes are little-endian: byte k = `word[8k+7:8k]`, with k = `addr[1:0]`. A halfword uses k = `addr[1]`*2.
- Loads, from the word captured in WAIT:
  - LB/LH: sign-extend to 32 bits.
  - LBU/LHU: zero-extend to 32 bits.
  - LW: pass the word through.
- SB/SH merge: the word captured in WAIT, with only the addressed lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`. Other bytes are preserved bit-exact.
- RESP always returns to IDLE on the next edge. The core has no backpressure on responses.
- `req_valid` while not IDLE is ignored and not queued. The core must hold the request until it sees `req_ready`.

## Timing
- Reset (`rst_n` low, takes effect immediately and asynchronously):
  - State goes to IDLE; `req_ready`=1.
  - `resp_valid`, `resp_err`, `mem_read_enable`, `mem_write_enable` = 0.
  - `resp_rdata`, `mem_addr`, `mem_write_value` = 0.
- Reset mid-operation aborts the access. An RMW in READ or WAIT leaves memory unchanged. Once the WRITE edge has occurred, the write stands.
- Latency, counted in cycles after the accept edge until `resp_valid`:
  - Error: 1.
  - SW: 2.
  - Load: 3.
  - SB/SH: 4.
- Throughput: the next accept is possible on the edge where RESP ends (IDLE entered). Back-to-back SW therefore completes every 3 cycles.
- `mem_addr` is held stable from READ through WRITE.
- `mem_read_enable` and `mem_write_enable` are never high together.
- Each enable is high for exactly one cycle per access.

## Test plan
- SW 0xAABBCCDD @0x0, then LW @0x0 → store RESP at +2 with err=0; load `resp_rdata`=0xAABBCCDD at +3.
- After word 0x11223344 @0x4: LB @0x7 → 0x00000011; LBU @0x6 → 0x00000022; LH @0x4 → 0x00003344. Then SW 0xFFFF8080 @0x4: LH @0x4 → 0xFFFF8080, LHU @0x4 → 0x00008080.
- Word 0xAABBCCDD @0x8, then SB 0x55 @0x9 and SH 0x1234 @0xA → LW @0x8 = 0x123455DD. Exactly one `mem_write_enable` pulse per store, at cycle +3.
- Error cases, each giving `resp_err`=1 at +1 with no mem enable asserted:
  - LH @0x1.
  - SW @0x2.
  - LW @`DEPTH`.
  - funct3=011.
  - Store with funct3=100.
- Legal boundary: LW @`DEPTH-4` → err=0.
- Assert `rst_n` low during WAIT of SB @0x0 over a word 0xAABBCCDD → all outputs drop to reset values immediately; a following LW @0x0 returns 0xAABBCCDD.
- Hold `req_valid` high continuously with alternating SW/LW → `req_ready` low except in IDLE, and no request is lost or duplicated.
